// File: rtl/noc_pkg.sv
// Shared packet format for the mesh NoC injector/ejector: field positions,
// packet struct and packet type enum.
package noc_pkg;

    localparam int unsigned PAYLOAD_W = 40;
    localparam int unsigned PKT_W     = 57;
    localparam int unsigned YHOP_LSB  = 40;
    localparam int unsigned XHOP_LSB  = 42;
    localparam int unsigned YDIR_BIT  = 45;
    localparam int unsigned XDIR_BIT  = 46;
    localparam int unsigned SRCX_LSB  = 47;
    localparam int unsigned SRCY_LSB  = 50;
    localparam int unsigned TYPE_LSB  = 52;
    localparam int unsigned SEQ_LSB   = 54;

    typedef enum logic [1:0] {
        PT_DATA = 2'd0,
        PT_REQ  = 2'd1,
        PT_RESP = 2'd2,
        PT_CTRL = 2'd3
    } pkt_type_e;

    // Field widths follow from the LSB map so struct and constants cannot drift.
    typedef struct packed {
        logic [PKT_W-SEQ_LSB-1:0]      seq;
        pkt_type_e                     ptype;
        logic [TYPE_LSB-SRCY_LSB-1:0]  src_y;
        logic [SRCY_LSB-SRCX_LSB-1:0]  src_x;
        logic [SRCX_LSB-XDIR_BIT-1:0]  x_dir;
        logic [XDIR_BIT-YDIR_BIT-1:0]  y_dir;
        logic [YDIR_BIT-XHOP_LSB-1:0]  x_hop;
        logic [XHOP_LSB-YHOP_LSB-1:0]  y_hop;
        logic [PAYLOAD_W-1:0]          payload;
    } pkt_t;

    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/noc_pkt_fifo.sv
// Synchronous packet FIFO with count; shared by the injector and ejector.
module noc_pkt_fifo #(
    parameter int unsigned WIDTH = 57,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_c, pop_ok_c;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    // Head reads as zero while empty so the output bus is quiet.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        push_ok_c = push && !full;
        pop_ok_c  = pop && !empty;
        wr_ptr_d  = push_ok_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop_ok_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(push_ok_c) - CW'(pop_ok_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/noc_pe_injector.sv
// PE-side packet encoder: classifies requests, stamps route/source/seq fields
// and queues packets for the router's PE input port.
module noc_pe_injector
    import noc_pkg::*;
#(
    parameter int unsigned LOCAL_X    = 0,
    parameter int unsigned LOCAL_Y    = 0,
    parameter int unsigned MESH_X     = 3,
    parameter int unsigned MESH_Y     = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [2:0]                    req_dest_x,
    input  logic [1:0]                    req_dest_y,
    input  logic [1:0]                    req_type,
    input  logic [PAYLOAD_W-1:0]          req_payload,
    output logic                          pkt_valid,
    input  logic                          pkt_ready,
    output logic [PKT_W-1:0]              pkt_data,
    output logic                          err_self,
    output logic                          err_range,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic [15:0]                   sent_cnt
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_ENQ        = 2'd1;
    localparam logic [1:0] ST_DROP_RANGE = 2'd2;
    localparam logic [1:0] ST_DROP_SELF  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [2:0]  seq_q, seq_d;
    logic [15:0] sent_cnt_q, sent_cnt_d;
    logic        fifo_full, fifo_empty;
    logic        push_c, pop_c;
    pkt_t        pkt_c;

    assign req_ready = !fifo_full;
    assign pkt_valid = !fifo_empty;
    assign err_range = (state_q == ST_DROP_RANGE);
    assign err_self  = (state_q == ST_DROP_SELF);
    assign sent_cnt  = sent_cnt_q;

    // Accept-path classification; range errors win over self-address.
    always_comb begin
        state_d = ST_IDLE;
        push_c  = 1'b0;
        if (req_valid && !fifo_full) begin
            if ((4'(req_dest_x) >= 4'(MESH_X)) || (4'(req_dest_y) >= 4'(MESH_Y))) begin
                state_d = ST_DROP_RANGE;
            end else if ((4'(req_dest_x) == 4'(LOCAL_X)) && (4'(req_dest_y) == 4'(LOCAL_Y))) begin
                state_d = ST_DROP_SELF;
            end else begin
                state_d = ST_ENQ;
                push_c  = 1'b1;
            end
        end
        pop_c      = pkt_valid && pkt_ready;
        seq_d      = push_c ? seq_q + 3'd1 : seq_q;
        sent_cnt_d = (pop_c && (sent_cnt_q != 16'hFFFF)) ? sent_cnt_q + 16'd1 : sent_cnt_q;
    end

    // Packet encoder; a direction bit is only set when its hop is non-zero.
    always_comb begin
        pkt_c         = '0;
        pkt_c.payload = req_payload;
        pkt_c.y_hop   = 2'(abs_diff(4'(req_dest_y), 4'(LOCAL_Y)));
        pkt_c.x_hop   = 3'(abs_diff(4'(req_dest_x), 4'(LOCAL_X)));
        pkt_c.y_dir   = (4'(req_dest_y) > 4'(LOCAL_Y));
        pkt_c.x_dir   = (4'(req_dest_x) > 4'(LOCAL_X));
        pkt_c.src_x   = 3'(LOCAL_X);
        pkt_c.src_y   = 2'(LOCAL_Y);
        pkt_c.ptype   = pkt_type_e'(req_type);
        pkt_c.seq     = seq_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            seq_q      <= '0;
            sent_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            sent_cnt_q <= sent_cnt_d;
        end
    end

    noc_pkt_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_c),
        .wr_data (pkt_c),
        .pop     (pop_c),
        .rd_data (pkt_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (occupancy)
    );

endmodule

// File: tb/tb_noc_pe_injector.sv
// Directed + random bench for noc_pe_injector at node (1,1) of a 3x3 mesh,
// checked cycle by cycle against a queue-based reference model.
module tb_noc_pe_injector;

    localparam int LX = 1;
    localparam int LY = 1;
    localparam int MX = 3;
    localparam int MY = 3;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_dest_x;
    logic [1:0]  req_dest_y;
    logic [1:0]  req_type;
    logic [39:0] req_payload;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [56:0] pkt_data;
    logic        err_self;
    logic        err_range;
    logic [2:0]  occupancy;
    logic [15:0] sent_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [56:0] mq[$];
    int          m_seq;
    int          m_sent;
    bit          m_err_r, m_err_s, m_acc;

    always #5 clk = ~clk;

    noc_pe_injector #(
        .LOCAL_X(LX), .LOCAL_Y(LY), .MESH_X(MX), .MESH_Y(MY), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest_x(req_dest_x), .req_dest_y(req_dest_y),
        .req_type(req_type), .req_payload(req_payload),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
        .err_self(err_self), .err_range(err_range),
        .occupancy(occupancy), .sent_cnt(sent_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [56:0] encode(input int dx, input int dy, input int ty,
                                           input logic [39:0] pl, input int sq);
        longint unsigned v;
        int xh, yh, xd, yd;
        xh = (dx > LX) ? dx - LX : LX - dx;
        yh = (dy > LY) ? dy - LY : LY - dy;
        xd = (dx > LX) ? 1 : 0;
        yd = (dy > LY) ? 1 : 0;
        v = 64'(pl);
        v += 64'(yh) * (64'd1 << 40);
        v += 64'(xh) * (64'd1 << 42);
        v += 64'(yd) * (64'd1 << 45);
        v += 64'(xd) * (64'd1 << 46);
        v += 64'(LX) * (64'd1 << 47);
        v += 64'(LY) * (64'd1 << 50);
        v += 64'(ty) * (64'd1 << 52);
        v += 64'(sq) * (64'd1 << 54);
        return v[56:0];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_seq = 0;
        m_sent = 0;
        m_err_r = 0;
        m_err_s = 0;
        m_acc = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs now on the pins.
    task automatic model_edge();
        bit full_before, rng, slf;
        full_before = (mq.size() >= DEPTH);
        m_acc   = req_valid && !full_before;
        rng     = (int'(req_dest_x) >= MX) || (int'(req_dest_y) >= MY);
        slf     = (int'(req_dest_x) == LX) && (int'(req_dest_y) == LY);
        m_err_r = m_acc && rng;
        m_err_s = m_acc && !rng && slf;
        if (pkt_ready && mq.size() > 0) begin
            void'(mq.pop_front());
            if (m_sent < 65535) m_sent++;
        end
        if (m_acc && !rng && !slf) begin
            mq.push_back(encode(int'(req_dest_x), int'(req_dest_y), int'(req_type), req_payload, m_seq));
            m_seq = (m_seq + 1) % 8;
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".req_ready"}, 64'(req_ready), 64'(mq.size() < DEPTH));
        chk({ph, ".pkt_valid"}, 64'(pkt_valid), 64'(mq.size() > 0));
        chk({ph, ".pkt_data"},  64'(pkt_data),  (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
        chk({ph, ".occupancy"}, 64'(occupancy), 64'(mq.size()));
        chk({ph, ".err_self"},  64'(err_self),  64'(m_err_s));
        chk({ph, ".err_range"}, 64'(err_range), 64'(m_err_r));
        chk({ph, ".sent_cnt"},  64'(sent_cnt),  64'(m_sent));
    endtask

    task automatic tick(input string ph);
        model_edge();
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    task automatic set_req(input int dx, input int dy, input int ty, input logic [39:0] pl);
        req_valid   = 1'b1;
        req_dest_x  = 3'(dx);
        req_dest_y  = 2'(dy);
        req_type    = 2'(ty);
        req_payload = pl;
    endtask

    // Present one request and hold it until accepted, within a cycle budget.
    task automatic send(input string ph, input int dx, input int dy, input int ty,
                        input logic [39:0] pl, input int budget);
        bit done;
        done = 0;
        set_req(dx, dy, ty, pl);
        for (int i = 0; i < budget && !done; i++) begin
            tick(ph);
            done = m_acc;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s.send_timeout: observed not accepted expected accepted", ph);
        end
        req_valid = 1'b0;
    endtask

    task automatic idle(input string ph, input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(ph);
    endtask

    initial begin
        logic [56:0] seqs;
        int          s0;

        rst_n = 1'b0; req_valid = 1'b0; req_dest_x = '0; req_dest_y = '0;
        req_type = '0; req_payload = '0; pkt_ready = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: encoding of a simple packet, held at the output
        send("t1", 2, 0, 1, 40'hABCDEF0123, 4);
        chk("t1.exact_pkt", 64'(pkt_data), 64'h0014C5ABCDEF0123);
        idle("t1.hold", 2);
        pkt_ready = 1'b1;
        idle("t1.drain", 2);

        // 2: self-addressed drop
        send("t2", 1, 1, 0, 40'h1111111111, 4);
        chk("t2.self_pulse", 64'(err_self), 64'd1);
        idle("t2.after", 1);
        chk("t2.self_clear", 64'(err_self), 64'd0);
        send("t2.legal", 0, 2, 2, 40'h2222222222, 4);
        idle("t2.drain", 2);

        // 3: out-of-range drops, range wins over self
        send("t3.x", 3, 0, 0, 40'h3333333333, 4);
        chk("t3.range_x", 64'(err_range), 64'd1);
        send("t3.y", 1, 3, 0, 40'h4444444444, 4);
        chk("t3.range_y", 64'(err_range), 64'd1);
        chk("t3.not_self", 64'(err_self), 64'd0);
        idle("t3.after", 2);

        // 4: fill with backpressure, 5th held, then drain
        pkt_ready = 1'b0;
        s0 = m_sent;
        for (int i = 0; i < 4; i++) send("t4.fill", 0, 0, 3, 40'(64'h500 + i), 2);
        chk("t4.occ_full", 64'(occupancy), 64'd4);
        chk("t4.ready_low", 64'(req_ready), 64'd0);
        set_req(2, 2, 3, 40'h504);
        for (int i = 0; i < 3; i++) tick("t4.held");
        pkt_ready = 1'b1;
        send("t4.fifth", 2, 2, 3, 40'h504, 6);
        idle("t4.drain", 6);
        chk("t4.sent5", 64'(sent_cnt), 64'(s0 + 5));

        // 5: streaming with seq wrap
        for (int i = 0; i < 9; i++) send("t5", i % 3, (i + 1) % 3 == 1 ? 2 : 0, 1, 40'(i), 3);
        idle("t5.drain", 2);

        // 6: async reset mid-operation
        pkt_ready = 1'b0;
        send("t6.a", 0, 0, 0, 40'h600, 2);
        send("t6.b", 2, 1, 0, 40'h601, 2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6.in_reset");
        chk("t6.valid_low", 64'(pkt_valid), 64'd0);
        @(posedge clk); #1;
        check_all("t6.reset_edge");
        rst_n = 1'b1;
        send("t6.post", 2, 2, 0, 40'h602, 2);
        seqs = pkt_data;
        chk("t6.seq0", 64'(seqs[56:54]), 64'd0);
        pkt_ready = 1'b1;
        idle("t6.drain", 2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            req_valid   = ($urandom_range(0, 3) != 0);
            req_dest_x  = 3'($urandom_range(0, 4));
            req_dest_y  = 2'($urandom_range(0, 3));
            req_type    = 2'($urandom_range(0, 3));
            req_payload = {8'($urandom), 32'($urandom)};
            pkt_ready   = ($urandom_range(0, 9) < 6);
            tick("rand");
        end
        idle("rand.end", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
